// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : EXE-stage pipeline register with valid/ready handshake, flush and
//            an optional 2-entry skid buffer (enabled by PIPE_STAGE_REG_SKID_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int DATA_W = 136,
    parameter int CTRL_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

`ifdef PIPE_STAGE_REG_SKID_EN
    localparam bit SKID_EN = 1'b1;
`else
    localparam bit SKID_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                push, pop;

    assign out_valid = (state_q != EMPTY);
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occ       = state_q;

`ifdef PIPE_STAGE_REG_SKID_EN
    // Depends only on stored state, so it never combinationally tracks out_ready.
    assign in_ready = rst & (state_q != TWO);
`else
    assign in_ready = rst & (!out_valid | out_ready);
`endif

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Flush wins: any push this cycle is dropped, any pop is treated as consumed.
            state_d     = EMPTY;
            main_ctrl_d = '0;
            main_data_d = '0;
            skid_ctrl_d = '0;
            skid_data_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d     = ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (push && SKID_EN) begin
                        state_d     = TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (pop) begin
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                        main_data_d = '0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                        skid_data_d = '0;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    main_data_d = '0;
                    skid_ctrl_d = '0;
                    skid_data_d = '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Scoreboard bench for pipe_stage_reg; works with or without
//            PIPE_STAGE_REG_SKID_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int DATA_W = 136;
    localparam int CTRL_W = 10;
`ifdef PIPE_STAGE_REG_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occ;

    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 1'b0;
    entry_t exp_q[$];

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d = '0;
        for (int i = 0; i < (DATA_W + 31) / 32; i++)
            d = (d << 32) | DATA_W'($urandom);
        return d;
    endfunction

    // One stimulus cycle: drive after the falling edge, record accepted entries.
    task automatic cycle(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input bit ordy, input bit fl);
        entry_t e;
        @(negedge clk);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #2;
        if (in_valid && in_ready && !flush) begin
            e.ctrl = c;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compares presented outputs against the model before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && rst) begin
                chk("occ", DATA_W'(occ), DATA_W'(exp_q.size()));
                chk("out_valid", DATA_W'(out_valid), DATA_W'(exp_q.size() > 0));
                chk("in_ready", DATA_W'(in_ready),
                    DATA_W'((exp_q.size() < DEPTH) || (DEPTH == 1 && out_ready)));
                if (exp_q.size() > 0) begin
                    chk("out_ctrl", DATA_W'(out_ctrl), DATA_W'(exp_q[0].ctrl));
                    chk("out_data", out_data, exp_q[0].data);
                    if (out_ready) void'(exp_q.pop_front());
                end else begin
                    chk("out_ctrl_zero", DATA_W'(out_ctrl), '0);
                    chk("out_data_zero", out_data, '0);
                end
                if (flush) exp_q.delete();
            end
        end
    end

    initial begin
        // Reset state while rst is low.
        #12;
        chk("rst_in_ready", DATA_W'(in_ready), '0);
        chk("rst_out_valid", DATA_W'(out_valid), '0);
        chk("rst_occ", DATA_W'(occ), '0);
        chk("rst_out_data", out_data, '0);
        @(negedge clk);
        #4 rst = 1'b1;
        mon_en = 1'b1;

        // Streaming ctrl 1..4 with out_ready high.
        for (int i = 1; i <= 4; i++) cycle(1'b1, CTRL_W'(i), rand_data(), 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Stall: A then B under back-pressure, then drain.
        cycle(1'b1, CTRL_W'(10'h0A), DATA_W'(136'h3A5), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, CTRL_W'(10'h0B), DATA_W'(136'h111), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Fill, then flush with a simultaneous push.
        cycle(1'b1, CTRL_W'(1), rand_data(), 1'b0, 1'b0);
        cycle(1'b1, CTRL_W'(2), rand_data(), 1'b0, 1'b0);
        cycle(1'b1, CTRL_W'(3), rand_data(), 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Push and pop together while one entry is held.
        cycle(1'b1, CTRL_W'(5), rand_data(), 1'b0, 1'b0);
        cycle(1'b1, CTRL_W'(6), rand_data(), 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 10) < 7, CTRL_W'($urandom), rand_data(),
                  ($urandom % 10) < 6, ($urandom % 25) == 0);

        // Asynchronous reset mid-operation with storage filled.
        cycle(1'b1, CTRL_W'(7), rand_data(), 1'b0, 1'b0);
        cycle(1'b1, CTRL_W'(8), rand_data(), 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #3;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_out_valid", DATA_W'(out_valid), '0);
        chk("async_out_ctrl", DATA_W'(out_ctrl), '0);
        chk("async_out_data", out_data, '0);
        chk("async_occ", DATA_W'(occ), '0);
        chk("async_in_ready", DATA_W'(in_ready), '0);
        exp_q.delete();
        @(negedge clk);
        #4 rst = 1'b1;
        mon_en = 1'b1;
        cycle(1'b1, CTRL_W'(9), rand_data(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        @(negedge clk);
        #3;
        chk("final_empty", DATA_W'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
